// File: rtl/test2.sv
// rtl/test2.sv - registered unsigned adder of two W-bit operands, LATENCY-deep sum pipeline
// Optional input capture register enabled by defining TEST2_INPUT_REG_EN.
module test2 #(
  parameter int W       = 3,
  parameter int LATENCY = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W:0]   c
);

  if (LATENCY < 1 || LATENCY > 4) begin : g_latency_check
    $error("test2: LATENCY must be in range 1..4");
  end

  logic [W-1:0] op_a;
  logic [W-1:0] op_b;

`ifdef TEST2_INPUT_REG_EN
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a;
      b_q <= b;
    end
  end

  assign op_a = a_q;
  assign op_b = b_q;
`else
  assign op_a = a;
  assign op_b = b;
`endif

  // Both operands zero-extended so the carry lands in the top sum bit.
  logic [W:0] sum_d;
  assign sum_d = {1'b0, op_a} + {1'b0, op_b};

  logic [W:0] pipe_q [LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= sum_d;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign c = pipe_q[LATENCY-1];

endmodule

// File: tb/tb_test2.sv
// tb/tb_test2.sv - directed bench for test2 at LATENCY=1 and LATENCY=3
// Honours TEST2_INPUT_REG_EN by adding one edge of expected latency.
module tb_test2;

`ifdef TEST2_INPUT_REG_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic       clk;
  logic       rst_n;
  logic [2:0] a;
  logic [2:0] b;
  logic [3:0] c1;
  logic [3:0] c3;

  int n_vec;
  int n_err;

  test2 #(.W(3), .LATENCY(1)) u_lat1 (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .c     (c1)
  );

  test2 #(.W(3), .LATENCY(3)) u_lat3 (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .c     (c3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] a;
    logic [2:0] b;
    logic [3:0] exp_c;
  } vec_t;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (%b), expected %0d", name, act, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic step(input logic [2:0] ta, input logic [2:0] tb);
    @(negedge clk);
    a = ta;
    b = tb;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs [10];
  int   exp3;

  initial begin
    n_vec = 0;
    n_err = 0;
    vecs[0] = '{3'd0, 3'd0, 4'd0};
    vecs[1] = '{3'd3, 3'd4, 4'd7};
    vecs[2] = '{3'd7, 3'd7, 4'd14};
    vecs[3] = '{3'd7, 3'd0, 4'd7};
    vecs[4] = '{3'd0, 3'd7, 4'd7};
    vecs[5] = '{3'd5, 3'd2, 4'd7};
    vecs[6] = '{3'd4, 3'd4, 4'd8};
    vecs[7] = '{3'd6, 3'd5, 4'd11};
    vecs[8] = '{3'd2, 3'd3, 4'd5};
    vecs[9] = '{3'd1, 3'd6, 4'd7};

    // Reset held with live inputs and running clock.
    rst_n = 1'b0;
    a = 3'd5;
    b = 3'd3;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_hold_lat1", c1, 4'd0);
      check("reset_hold_lat3", c3, 4'd0);
    end

    // Release, let sums propagate, then assert reset mid-cycle.
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4 + EXTRA) @(posedge clk);
    #1;
    check("pre_async_lat1", c1, 4'd8);
    check("pre_async_lat3", c3, 4'd8);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_lat1", c1, 4'd0);
    check("async_reset_lat3", c3, 4'd0);
    @(negedge clk);
    a = 3'd0;
    b = 3'd0;
    rst_n = 1'b1;

    // Single-edge timing of the LATENCY=1 instance.
    step(3'd0, 3'd0);
    check("zero_lat1", c1, 4'd0);
    step(3'd3, 3'd4);
    check("first_edge_lat1", c1, (EXTRA != 0) ? 4'd0 : 4'd7);
    step(3'd3, 3'd4);
    check("second_edge_lat1", c1, 4'd7);

    // Steady-state table: each vector held until both pipelines have filled.
    for (int i = 0; i < 10; i++) begin
      step(vecs[i].a, vecs[i].b);
      repeat (2 + EXTRA) @(posedge clk);
      #1;
      check($sformatf("vec%0d_lat1", i), c1, vecs[i].exp_c);
      check($sformatf("vec%0d_lat3", i), c3, vecs[i].exp_c);
    end

    // Flush with zeros, then back-to-back samples through LATENCY=3.
    for (int i = 0; i < 4; i++) step(3'd0, 3'd0);
    check("flush_lat3", c3, 4'd0);
    for (int k = 0; k < 7; k++) begin
      if (k < 3) step(3'(k + 1), 3'(k + 1));
      else step(3'd0, 3'd0);
      exp3 = (k >= 2 + EXTRA && k <= 4 + EXTRA) ? 2 * (k - 1 - EXTRA) : 0;
      check($sformatf("b2b_lat3_edge%0d", k), c3, 4'(exp3));
    end

    // Reset with (3,3) in flight: it must never emerge after release.
    step(3'd1, 3'd1);
    step(3'd2, 3'd2);
    step(3'd3, 3'd3);
    @(negedge clk);
    rst_n = 1'b0;
    a = 3'd1;
    b = 3'd2;
    #1;
    check("inflight_reset_lat3", c3, 4'd0);
    @(posedge clk);
    #1;
    check("inflight_hold_lat3", c3, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("post_reset_lat3_edge%0d", k), c3, (k >= 2 + EXTRA) ? 4'd3 : 4'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
